mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one registered physical memory port between the IF fetch port and the MEM data port.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants under contention instead of data-side priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [MASK_W-1:0] d_byte_enable,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [MASK_W-1:0] pmem_byte_enable,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [DATA_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                pmem_read_q, pmem_read_d;
    logic                pmem_write_q, pmem_write_d;
    logic [MASK_W-1:0]   pmem_be_q, pmem_be_d;
    logic [ADDR_W-1:0]   pmem_addr_q, pmem_addr_d;
    logic [DATA_W-1:0]   pmem_wdata_q, pmem_wdata_d;
    logic                i_resp_d, d_resp_d;
    logic                d_req, pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;
    logic last_grant_q, last_grant_d;
`endif

    assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Under contention the side that was not served last wins.
    assign pick_d = d_req && (!i_read || (last_grant_q != GRANT_D));
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d      = state_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_be_d    = pmem_be_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    // A simultaneous read and write is treated as a write.
                    state_d      = BUSY_D;
                    pmem_read_d  = ~d_write;
                    pmem_write_d = d_write;
                    pmem_be_d    = d_write ? d_byte_enable : {MASK_W{1'b1}};
                    pmem_addr_d  = d_addr;
                    pmem_wdata_d = d_wdata;
                end else if (i_read) begin
                    state_d      = BUSY_I;
                    pmem_read_d  = 1'b1;
                    pmem_write_d = 1'b0;
                    pmem_be_d    = {MASK_W{1'b1}};
                    pmem_addr_d  = i_addr;
                end
            end
            BUSY_I: begin
                if (pmem_resp) begin
                    i_resp_d     = ~reset;
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = GRANT_I;
`endif
                end
            end
            BUSY_D: begin
                if (pmem_resp) begin
                    d_resp_d     = ~reset;
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = GRANT_D;
`endif
                end
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_be_q    <= '0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= GRANT_I;
`endif
        end else begin
            state_q      <= state_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_be_q    <= pmem_be_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign i_resp           = i_resp_d;
    assign d_resp           = d_resp_d;
    assign i_rdata          = pmem_rdata;
    assign d_rdata          = pmem_rdata;
    assign pmem_read        = pmem_read_q;
    assign pmem_write       = pmem_write_q;
    assign pmem_byte_enable = pmem_be_q;
    assign pmem_addr        = pmem_addr_q;
    assign pmem_wdata       = pmem_wdata_q;

    a_no_read_and_write: assert property (@(posedge clk) disable iff (reset) !(d_read && d_write));

endmodule
